// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_unit
// Brief    : EX-stage forwarding selects plus load-use stall / flush control.
//            Optional macro HFU_ID_BYPASS_EN adds id_bypass_a / id_bypass_b.
// Revision : 1.0
// ============================================================================
module hazard_forward_unit #(
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush
`ifdef HFU_ID_BYPASS_EN
  ,
  output logic                  id_bypass_a,
  output logic                  id_bypass_b
`endif
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] rd;
  } stage_t;

  localparam logic [1:0] c_fwd_rf     = 2'b00;
  localparam logic [1:0] c_fwd_wb     = 2'b01;
  localparam logic [1:0] c_fwd_mem    = 2'b10;
  localparam logic [1:0] c_stall_load = 2'(LOAD_USE_STALL - 1);
  localparam stage_t     c_bubble     = '0;

  function automatic logic f_match(input stage_t s, input logic [REG_ADDR_W-1:0] r);
    return s.valid & s.reg_write & (s.rd != '0) & (s.rd == r);
  endfunction

  stage_t     r_ex, r_mem, r_wb;
  logic [1:0] r_stall_cnt;
  logic [1:0] r_fwd_a, r_fwd_b;

  stage_t     w_id_stage;
  logic       w_ex_rs1, w_ex_rs2, w_mem_rs1, w_mem_rs2;
  logic       w_load_use, w_stall, w_advance;
  logic [1:0] w_fwd_a_nxt, w_fwd_b_nxt;
  logic       w_shadow_unused;

  assign w_id_stage = '{valid: 1'b1, reg_write: id_reg_write,
                        mem_read: id_mem_read, rd: id_rd};

  assign w_ex_rs1  = f_match(r_ex,  id_rs1);
  assign w_ex_rs2  = f_match(r_ex,  id_rs2);
  assign w_mem_rs1 = f_match(r_mem, id_rs1);
  assign w_mem_rs2 = f_match(r_mem, id_rs2);

  assign w_load_use = id_valid & r_ex.valid & r_ex.mem_read & (r_ex.rd != '0) &
                      ((id_uses_rs1 & (id_rs1 == r_ex.rd)) |
                       (id_uses_rs2 & (id_rs2 == r_ex.rd)));

  // A taken branch makes the stalled ID instruction wrong-path, so it wins.
  assign w_stall   = (w_load_use | (r_stall_cnt != 2'd0)) & ~ex_branch_taken;
  assign w_advance = id_valid & ~w_stall & ~ex_branch_taken;

  // The ex shadow becomes EX/MEM and mem becomes MEM/WB once ID reaches EX.
  assign w_fwd_a_nxt = !id_uses_rs1 ? c_fwd_rf  :
                       w_ex_rs1     ? c_fwd_mem :
                       w_mem_rs1    ? c_fwd_wb  : c_fwd_rf;
  assign w_fwd_b_nxt = !id_uses_rs2 ? c_fwd_rf  :
                       w_ex_rs2     ? c_fwd_mem :
                       w_mem_rs2    ? c_fwd_wb  : c_fwd_rf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex        <= c_bubble;
      r_mem       <= c_bubble;
      r_wb        <= c_bubble;
      r_stall_cnt <= 2'd0;
      r_fwd_a     <= c_fwd_rf;
      r_fwd_b     <= c_fwd_rf;
    end else begin
      r_wb    <= r_mem;
      r_mem   <= r_ex;
      r_ex    <= w_advance ? w_id_stage  : c_bubble;
      r_fwd_a <= w_advance ? w_fwd_a_nxt : c_fwd_rf;
      r_fwd_b <= w_advance ? w_fwd_b_nxt : c_fwd_rf;
      if (ex_branch_taken) begin
        r_stall_cnt <= 2'd0;
      end else if (r_stall_cnt != 2'd0) begin
        r_stall_cnt <= r_stall_cnt - 2'd1;
      end else if (w_load_use) begin
        r_stall_cnt <= c_stall_load;
      end
    end
  end

  assign ForwardA     = r_fwd_a;
  assign ForwardB     = r_fwd_b;
  assign pc_write     = ~w_stall;
  assign if_id_write  = ~w_stall;
  assign id_ex_bubble = w_stall | ex_branch_taken;
  assign if_id_flush  = ex_branch_taken;

`ifdef HFU_ID_BYPASS_EN
  // Only the oldest producer needs an ID-side bypass; younger ones forward in EX.
  assign id_bypass_a = f_match(r_wb, id_rs1) & ~w_ex_rs1 & ~w_mem_rs1;
  assign id_bypass_b = f_match(r_wb, id_rs2) & ~w_ex_rs2 & ~w_mem_rs2;
`else
`endif

  assign w_shadow_unused = ^{r_mem.mem_read, r_wb};

endmodule
`default_nettype wire
